// File: rtl/pulse_sync_tx_pkg.sv
// Shared types and constants for the pulse synchronizer transmitter slice.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    REQ     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int unsigned SYNC_STAGES   = 2;
  localparam int unsigned TMO_W_DEFAULT = 8;

endpackage

// File: rtl/pulse_sync_tx_if.sv
// Source-side valid/ready word handshake into pulse_sync_tx.
interface pulse_sync_tx_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/pulse_sync_tx_sync_2ff.sv
// Multi-flop synchronizer for a single CDC control bit, with clock enable.
module sync_2ff
  import pulse_sync_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the chain while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (en_i) begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_tx.sv
// Source-domain transmitter: holds a word on data_out and runs a four-phase
// stb/ack exchange against a synchronized ack.
// Optional macro PULSE_SYNC_TX_TIMEOUT_EN adds a TMO_W-bit handshake timeout.
module pulse_sync_tx
  import pulse_sync_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  pulse_sync_tx_if.slave src,
  output logic [N-1:0] data_out,
  output logic         stb,
  input  logic         ack,
  output logic         busy,
  output logic         err
);

  if (TMO_W < 1) begin : g_bad_tmo_w
    $error("TMO_W must be at least 1");
  end

  state_e       state_q;
  logic [N-1:0] data_q;
  logic         stb_q;
  logic         ack_s;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ena),
    .d_i   (ack),
    .q_o   (ack_s)
  );

  assign src.in_ready = ena && (state_q == IDLE);

`ifdef PULSE_SYNC_TX_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             tmo_sat;

  assign tmo_sat = (tmo_q == '1);

  // Handshake FSM with data hold register, strobe and timeout counter;
  // a real ack_s transition always wins over a simultaneous saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      stb_q   <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else if (ena) begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (src.in_valid) begin
            data_q  <= src.in_data;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          tmo_q   <= '0;
          stb_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (ack_s) begin
            stb_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= RELEASE;
          end else if (tmo_sat) begin
            stb_q   <= 1'b0;
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= RELEASE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            tmo_q   <= '0;
            state_q <= IDLE;
          end else if (tmo_sat) begin
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err = err_q;
`else
  // Handshake FSM with data hold register and registered strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      stb_q   <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (src.in_valid) begin
            data_q  <= src.in_data;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          stb_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (ack_s) begin
            stb_q   <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign err = 1'b0;
`endif

  assign data_out = data_q;
  assign stb      = stb_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_sync_tx.sv
// Directed bench for pulse_sync_tx: scoreboard of accepted words checked at
// each strobe rise, plus a data-hold monitor and an ack synchronizer model.
`timescale 1ns/1ps
module tb_pulse_sync_tx;
  import pulse_sync_pkg::*;

  localparam int unsigned N = 8;
`ifdef PULSE_SYNC_TX_TIMEOUT_EN
  localparam int unsigned TMO_W = 4;
`else
  localparam int unsigned TMO_W = TMO_W_DEFAULT;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena   = 1'b0;
  logic         ack   = 1'b0;
  logic [N-1:0] data_out;
  logic         stb;
  logic         busy;
  logic         err;

  pulse_sync_tx_if #(.N(N)) src_if ();

  pulse_sync_tx #(.N(N), .TMO_W(TMO_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .src      (src_if.slave),
    .data_out (data_out),
    .stb      (stb),
    .ack      (ack),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int           n_pass  = 0;
  int           n_total = 0;
  int           cyc     = 0;
  logic [N-1:0] exp_q[$];
  int           acc_cyc[$];
  logic         s1 = 1'b0, s2 = 1'b0;   // model of the ack synchronizer
  logic         loop_en = 1'b0;
  logic         r1 = 1'b0, r2 = 1'b0;   // receiver-side loopback of stb

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: record accepts, advance models, run monitors.
  task automatic tick();
    logic         acc, en_b, ack_b, hold;
    logic         prev_stb;
    logic [N-1:0] prev_data;
    acc       = src_if.in_valid && src_if.in_ready;
    en_b      = ena;
    ack_b     = ack;
    prev_stb  = stb;
    prev_data = data_out;
    hold      = busy || stb || s2;
    if (acc) begin
      exp_q.push_back(src_if.in_data);
      acc_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (en_b) begin
      s2 = s1;
      s1 = ack_b;
    end
    if (hold) check("data_hold", data_out, prev_data);
    if (stb && !prev_stb) begin
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_data", data_out, exp_q.pop_front());
    end
    if (loop_en) begin
      r2  = r1;
      r1  = stb;
      ack = r2;
    end
  endtask

  task automatic wait_stb(input logic val, input int budget, input string tag);
    int n = 0;
    while (stb !== val && n < budget) begin
      tick();
      n++;
    end
    check(tag, stb, val);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic send(input logic [N-1:0] d);
    src_if.in_valid = 1'b1;
    src_if.in_data  = d;
    tick();
    src_if.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    src_if.in_valid = 1'b0;
    src_if.in_data  = '0;
    ena             = 1'b1;

    // 1. Reset then single transfer
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_stb", stb, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ready", src_if.in_ready, 1);
    send(8'hA5);
    check("t1_data", data_out, 8'hA5);
    check("t1_stb_setup", stb, 0);
    check("t1_ready_busy", src_if.in_ready, 0);
    tick();
    check("t1_stb_up", stb, 1);
    repeat (3) tick();
    ack = 1'b1;
    tick();
    tick();
    check("t1_stb_sync", stb, 1);
    tick();
    check("t1_stb_down", stb, 0);
    check("t1_release", busy, 1);
    repeat (3) tick();
    ack = 1'b0;
    tick();
    tick();
    check("t1_ready_sync", src_if.in_ready, 0);
    tick();
    check("t1_ready_back", src_if.in_ready, 1);
    check("t1_err", err, 0);

    // ack glitch in IDLE is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("glitch_idle_busy", busy, 0);
      check("glitch_idle_stb", stb, 0);
    end

    // 2. Back-to-back source with loopback responder
    loop_en = 1'b1;
    r1 = 1'b0;
    r2 = 1'b0;
    acc_cyc.delete();
    src_if.in_valid = 1'b1;
    src_if.in_data  = 8'h11;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc_cyc.size() == 1) src_if.in_data = 8'h22;
      if (acc_cyc.size() == 2) break;
    end
    src_if.in_valid = 1'b0;
    check("t2_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("t2_spacing", acc_cyc[1] - acc_cyc[0], 10);
    wait_stb(1'b1, 5, "t2_stb2_up");
    wait_idle(30, "t2_done");
    loop_en = 1'b0;
    ack = 1'b0;
    repeat (3) tick();

    // 3. Enable freeze during REQ
    send(8'h5A);
    wait_stb(1'b1, 5, "t3_stb_up");
    ena = 1'b0;
    check("t3_ready_frozen", src_if.in_ready, 0);
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stb_hold", stb, 1);
      check("t3_busy_hold", busy, 1);
    end
    ena = 1'b1;
    tick();
    tick();
    check("t3_nosync", stb, 1);
    tick();
    check("t3_resume", stb, 0);
    ack = 1'b0;
    wait_idle(10, "t3_idle");

    // 4. Reset mid-REQ
    send(8'h3C);
    wait_stb(1'b1, 5, "t4_stb_up");
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_async_stb", stb, 0);
    check("t4_async_data", data_out, 0);
    check("t4_async_busy", busy, 0);
    s1 = 1'b0;
    s2 = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t4_ready", src_if.in_ready, 1);
    check("t4_stb", stb, 0);

    // 6. Stale ack held beyond RELEASE entry
    send(8'hC3);
    wait_stb(1'b1, 5, "t6_stb_up");
    ack = 1'b1;
    wait_stb(1'b0, 6, "t6_stb_down");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t6_ready_held", src_if.in_ready, 0);
    end
    check("t6_busy", busy, 1);
    ack = 1'b0;
    tick();
    tick();
    check("t6_ready_sync", src_if.in_ready, 0);
    tick();
    check("t6_ready_back", src_if.in_ready, 1);

`ifdef PULSE_SYNC_TX_TIMEOUT_EN
    // 5. Timeout with ack never answering
    send(8'h77);
    wait_stb(1'b1, 5, "t5_stb_up");
    n = 0;
    while (stb === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("t5_tmo_len", n, 16);
    check("t5_err_pulse", err, 1);
    check("t5_release", busy, 1);
    tick();
    check("t5_err_clear", err, 0);
    check("t5_idle", src_if.in_ready, 1);
`else
    // Without the timeout, an unanswered request waits indefinitely
    send(8'h77);
    wait_stb(1'b1, 5, "t5_stb_up");
    n = 0;
    repeat (40) begin
      tick();
      if (stb === 1'b1 && err === 1'b0) n++;
    end
    check("t5_no_tmo", n, 40);
    ack = 1'b1;
    wait_stb(1'b0, 6, "t5_stb_down");
    ack = 1'b0;
    wait_idle(6, "t5_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
